// File: rtl/prbs15_pattern_gen.sv
// prbs15_pattern_gen: serial-link test-pattern source.
// Captures four bytes after reset and replays them newest-first n times.
// Then it runs a free-running PRBS (x^15+x^14+1) byte stream until the next reset.
module prbs15_pattern_gen #(
   parameter int Type     = 15,
   parameter int BusWidth = 8,
   parameter int NumWidth = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [BusWidth-1:0] InData,
   input  logic [NumWidth-1:0] n,
   output logic [BusWidth-1:0] OutData,
   output logic                PRBSEq
);

   localparam logic [1:0] ST_CAPTURE = 2'd0;
   localparam logic [1:0] ST_PATTERN = 2'd1;
   localparam logic [1:0] ST_PRBS    = 2'd2;

   logic [1:0]            state_reg;
   logic [1:0]            cap_cnt_reg;
   logic [1:0]            idx_reg;
   logic [NumWidth-1:0]   rep_reg;
   logic [NumWidth-1:0]   nreg_reg;
   logic [Type-1:0]       lfsr_reg;
   logic [BusWidth-1:0]   out_reg;
   logic                  prbseq_reg;

   logic [4*BusWidth-1:0] cap_flat;
   logic [BusWidth-1:0]   sel_byte;
   logic [Type-1:0]       lfsr_next;
   logic [BusWidth-1:0]   prbs_byte;
   logic                  step_bit;

   // One register per captured byte; capture slot k is written on capture edge k+1.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cap
         logic [BusWidth-1:0] byte_reg;
         // Load this slot when the capture counter points at it.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST)
               byte_reg <= '0;
            else if (state_reg == ST_CAPTURE && cap_cnt_reg == 2'(gi))
               byte_reg <= InData;
         end
         assign cap_flat[gi*BusWidth +: BusWidth] = byte_reg;
      end
   endgenerate

   // Replay order within one repetition is newest first: B3, B2, B1, B0.
   always_comb begin
      sel_byte = '0;
      case (idx_reg)
         2'd0:    sel_byte = cap_flat[3*BusWidth +: BusWidth];
         2'd1:    sel_byte = cap_flat[2*BusWidth +: BusWidth];
         2'd2:    sel_byte = cap_flat[1*BusWidth +: BusWidth];
         default: sel_byte = cap_flat[0*BusWidth +: BusWidth];
      endcase
   end

   // Advance the Fibonacci LFSR BusWidth steps; the first generated bit lands in the MSB.
   always_comb begin
      lfsr_next = lfsr_reg;
      prbs_byte = '0;
      step_bit  = 1'b0;
      for (int i = 0; i < BusWidth; i++) begin
         step_bit  = lfsr_next[Type-1] ^ lfsr_next[Type-2];
         lfsr_next = {lfsr_next[Type-2:0], step_bit};
         prbs_byte[BusWidth-1-i] = step_bit;
      end
   end

   // Sequencer: capture -> optional pattern replay -> terminal PRBS.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= ST_CAPTURE;
         cap_cnt_reg <= '0;
         idx_reg     <= '0;
         rep_reg     <= '0;
         nreg_reg    <= '0;
         lfsr_reg    <= '1;
         out_reg     <= '0;
         prbseq_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_CAPTURE: begin
               cap_cnt_reg <= cap_cnt_reg + 2'd1;
               if (cap_cnt_reg == 2'd3) begin
                  // n is sampled only here; later changes are ignored.
                  nreg_reg  <= n;
                  idx_reg   <= '0;
                  rep_reg   <= NumWidth'(1);
                  state_reg <= (n != '0) ? ST_PATTERN : ST_PRBS;
               end
            end
            ST_PATTERN: begin
               out_reg <= sel_byte;
               idx_reg <= idx_reg + 2'd1;
               if (idx_reg == 2'd3) begin
                  if (rep_reg == nreg_reg)
                     state_reg <= ST_PRBS;
                  else
                     rep_reg <= rep_reg + NumWidth'(1);
               end
            end
            ST_PRBS: begin
               out_reg    <= prbs_byte;
               prbseq_reg <= 1'b1;
               lfsr_reg   <= lfsr_next;
            end
            default: begin
               state_reg <= ST_CAPTURE;
            end
         endcase
      end
   end

   assign OutData = out_reg;
   assign PRBSEq  = prbseq_reg;

endmodule

// File: tb/tb_prbs15_pattern_gen.sv
// Testbench for prbs15_pattern_gen: table-driven scenarios, randomized runs,
// mid-pattern reset abort, and a long PRBS run against a bit-recurrence model.
module tb_prbs15_pattern_gen;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] InData = '0;
   logic [3:0] n = '0;
   logic [7:0] OutData;
   logic       PRBSEq;

   int passes = 0;
   int total  = 0;

   // Reference PRBS bit stream: 15 seed ones, then bit[t] = bit[t-15] ^ bit[t-14].
   bit mbits[$];

   typedef struct {
      logic [3:0][7:0] d;      // d[0] is the first captured byte
      logic [3:0]      nv;
      int              nprbs;
      bit              chkp;   // also compare first two PRBS bytes to constants
      logic [7:0]      p0;
      logic [7:0]      p1;
   } vec_t;

   vec_t vecs[4];

   prbs15_pattern_gen #(.Type(15), .BusWidth(8), .NumWidth(4)) dut (
      .CLK(CLK), .RST(RST), .InData(InData), .n(n),
      .OutData(OutData), .PRBSEq(PRBSEq)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [7:0] model_byte(input int j);
      logic [7:0] v;
      v = '0;
      for (int b = 0; b < 8; b++) v[7-b] = mbits[15 + 8*j + b];
      return v;
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      #2;
      chk("reset_out", 32'(OutData), 32'h0);
      chk("reset_eq", 32'(PRBSEq), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Full scenario. abort_at >= 0 asserts reset mid-cycle after that many pattern edges.
   task automatic run_scenario(input int id, input logic [3:0][7:0] d, input logic [3:0] nv,
                               input int nprbs, input bit noise, input bit chkp,
                               input logic [7:0] p0, input logic [7:0] p1, input int abort_at);
      int pat_edges;
      int start_pass;
      start_pass = passes;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         InData = d[k];
         n = (k == 3) ? nv : 4'($urandom);
         @(posedge CLK); #1;
         chk("capture_out", 32'(OutData), 32'h0);
         chk("capture_eq", 32'(PRBSEq), 32'h0);
      end
      pat_edges = 0;
      for (int r = 0; r < int'(nv); r++) begin
         for (int i = 0; i < 4; i++) begin
            if (noise) begin InData = 8'($urandom); n = 4'($urandom); end
            if (abort_at >= 0 && pat_edges == abort_at) begin
               #3 RST = 1'b1;
               #1;
               chk("abort_out", 32'(OutData), 32'h0);
               chk("abort_eq", 32'(PRBSEq), 32'h0);
               $display("scenario %0d: reset asserted during pattern after %0d edges", id, pat_edges);
               return;
            end
            @(posedge CLK); #1;
            chk("pattern_out", 32'(OutData), 32'(d[3-i]));
            chk("pattern_eq", 32'(PRBSEq), 32'h0);
            pat_edges++;
         end
      end
      for (int j = 0; j < nprbs; j++) begin
         if (noise) begin InData = 8'($urandom); n = 4'($urandom); end
         @(posedge CLK); #1;
         chk("prbs_out", 32'(OutData), 32'(model_byte(j)));
         chk("prbs_eq", 32'(PRBSEq), 32'h1);
         if (chkp && j == 0) chk("prbs_first", 32'(OutData), 32'(p0));
         if (chkp && j == 1) chk("prbs_second", 32'(OutData), 32'(p1));
      end
      $display("scenario %0d: bytes %h %h %h %h n=%0d prbs=%0d checks_ok=%0d",
               id, d[0], d[1], d[2], d[3], nv, nprbs, passes - start_pass);
   endtask

   initial begin
      logic [3:0][7:0] rd;
      logic [3:0]      rn;

      for (int t = 0; t < 15; t++) mbits.push_back(1'b1);
      for (int t = 15; t < 15 + 8*4200; t++) mbits.push_back(mbits[t-15] ^ mbits[t-14]);

      vecs[0] = '{d: {8'hDD, 8'hCC, 8'hBB, 8'hAA}, nv: 4'd4,  nprbs: 8, chkp: 1'b1, p0: 8'h00, p1: 8'h02};
      vecs[1] = '{d: {8'h44, 8'h33, 8'h22, 8'h11}, nv: 4'd1,  nprbs: 4, chkp: 1'b1, p0: 8'h00, p1: 8'h02};
      vecs[2] = '{d: {8'h12, 8'h34, 8'h56, 8'h78}, nv: 4'd0,  nprbs: 4, chkp: 1'b1, p0: 8'h00, p1: 8'h02};
      vecs[3] = '{d: {8'hA5, 8'h5A, 8'h00, 8'hFF}, nv: 4'd15, nprbs: 4, chkp: 1'b0, p0: 8'h00, p1: 8'h00};

      // Table-driven scenarios (spec examples plus max repetition count).
      for (int v = 0; v < 4; v++)
         run_scenario(v, vecs[v].d, vecs[v].nv, vecs[v].nprbs, 1'b0,
                      vecs[v].chkp, vecs[v].p0, vecs[v].p1, -1);

      // Randomized scenarios with noise on InData/n outside the capture window.
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < 4; k++) rd[k] = 8'($urandom);
         rn = 4'($urandom_range(0, 5));
         run_scenario(10 + s, rd, rn, 20, 1'b1, 1'b0, 8'h00, 8'h00, -1);
      end

      // Reset mid-pattern, then a clean capture must follow.
      run_scenario(20, {8'h04, 8'h03, 8'h02, 8'h01}, 4'd3, 0, 1'b0, 1'b0, 8'h00, 8'h00, 6);
      run_scenario(21, {8'h9C, 8'h7B, 8'h5A, 8'h3E}, 4'd2, 6, 1'b1, 1'b1, 8'h00, 8'h02, -1);

      // Long PRBS run against the reference stream.
      for (int k = 0; k < 4; k++) rd[k] = 8'($urandom);
      run_scenario(30, rd, 4'd2, 4096, 1'b1, 1'b0, 8'h00, 8'h00, -1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
